count_sequencer: RTL
====================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the counter width in bits.
REQ-002 The block SHALL have parameter STEP_DIV, default 4, giving the clock cycles per count step (legal range is 1 or more).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port CMD_VALID, input, 1 bit: a move command is offered.
REQ-006 The block SHALL have port CMD_TARGET, input, N bits: the requested final count, unsigned.
REQ-007 The block SHALL have port CMD_READY, output, 1 bit: a command is accepted when CMD_VALID and CMD_READY are both high at a rising edge.
REQ-008 The block SHALL have port ABORT, input, 1 bit: stop the current move.
REQ-009 The block SHALL have port Y, output, N bits: the current count.
REQ-010 The block SHALL have port DIR_OUT, output, 1 bit: the current direction, where 1 = up and 0 = down.
REQ-011 The block SHALL have port BUSY, output, 1 bit: high while in RUN.
REQ-012 The block SHALL have port DONE, output, 1 bit: a one-cycle pulse when a move completes.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 CMD_READY SHALL be high only in IDLE, decoded combinationally from the state register; BUSY SHALL be high only in RUN; DONE SHALL be high only in the DONE state.
REQ-015 On acceptance with CMD_TARGET != Y: the block SHALL latch the target, set DIR_OUT = (CMD_TARGET > Y), clear the prescaler to 0 and enter RUN.
REQ-016 On acceptance with CMD_TARGET == Y: the block SHALL enter DONE directly, with Y unchanged and DIR_OUT unchanged.
REQ-017 In RUN, the prescaler SHALL increment each cycle and wrap from STEP_DIV-1 to 0; a step tick SHALL occur in the cycle where the prescaler equals STEP_DIV-1.
REQ-018 On a tick, Y SHALL change by exactly 1 in direction DIR_OUT; with STEP_DIV=1, every RUN cycle SHALL be a tick.
REQ-019 When the step on an edge makes Y equal the latched target, the state SHALL become DONE on that same edge.
REQ-020 Latency: for distance D = |target - Y| at acceptance edge k, Y SHALL reach the target at edge k + D*STEP_DIV; DONE SHALL be high for the following cycle; the state SHALL be IDLE again from edge k + D*STEP_DIV + 1.
REQ-021 DONE SHALL always be followed by IDLE; it SHALL never be held for more than one cycle.
REQ-022 ABORT high in RUN SHALL cause a transition to IDLE at the next edge, with Y frozen at its current value, no step taken even if a tick coincides, and no DONE pulse.
REQ-023 ABORT SHALL be ignored in IDLE and DONE.
REQ-024 CMD_VALID SHALL be ignored outside IDLE, and CMD_TARGET SHALL only be sampled at acceptance.
REQ-025 Y SHALL never wrap: the counter saturates at 0 and at 2**N-1; targets are always in range, so saturation is a safety property only.
REQ-026 Y SHALL hold its value in IDLE and DONE, so a subsequent command starts from the final or aborted position.

Reset
REQ-027 While RESET is high, the block SHALL hold state = IDLE, Y = 0, DIR_OUT = 1, prescaler = 0, latched target = 0, BUSY = 0, DONE = 0 and CMD_READY = 1, irrespective of CLK.
REQ-028 RESET asserted mid-move SHALL abandon the move immediately with no DONE pulse, and no command SHALL be accepted while RESET is high.
REQ-029 On the first rising edge after RESET deasserts, the block SHALL be able to accept a command.

Structure
REQ-030 Package count_seq_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the default parameter constants.
REQ-031 Sub-module updn_step_counter SHALL hold the N-bit saturating up/down register, with inputs CLK, RESET, EN and DIR and output Q, stepping by 1 only when EN is high.
REQ-032 count_sequencer SHALL contain the FSM, the prescaler, the target register, the direction register, and the EN/DIR drive to the sub-module.

Verification (N=4, STEP_DIV=2 unless stated)
REQ-033 Scenario: reset, then command target 5 accepted at edge 0 -> Y=1,2,3,4,5 at edges 2,4,6,8,10; BUSY high for edges 0 through 10; DONE high for exactly one cycle after edge 10; CMD_READY high again after edge 11.
REQ-034 Scenario: from Y=5, command target 2 -> DIR_OUT=0; Y=4,3,2 at acceptance+2, +4 and +6; a single DONE pulse.
REQ-035 Scenario: from Y=7, command target 7 -> DONE high for the cycle after acceptance; Y stays 7; BUSY never rises.
REQ-036 Scenario: move 0->15 with ABORT high in the tick cycle at Y=3 -> no step that edge; Y stays 3; no DONE; IDLE next cycle; new command target 0 then counts down from 3.
REQ-037 Scenario: RESET pulsed between clock edges mid-move at Y=6 -> Y=0, DONE=0 and CMD_READY=1 immediately; CMD_VALID pulses during RUN and DONE have no effect.
REQ-038 Scenario: STEP_DIV=1, move 0->15 -> Y increments every cycle and reaches 15 at acceptance+15 with no wrap; a following target-15 command returns DONE only.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM state encoding and default sizing.
package count_seq_pkg;

    localparam int DEFAULT_N        = 8;
    localparam int DEFAULT_STEP_DIV = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/updn_step_counter.sv
// N-bit up/down counter that moves by one when enabled and sticks at 0 and at all-ones.
module updn_step_counter #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         EN,
    input  logic         DIR,
    output logic [N-1:0] Q
);

    localparam logic [N-1:0] MAX_VAL = '1;

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (EN) begin
            if (DIR && (count_q != MAX_VAL)) begin
                count_d = count_q + 1'b1;
            end else if (!DIR && (count_q != '0)) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Q = count_q;

endmodule

// File: rtl/count_sequencer.sv
// Moves a counter one step every STEP_DIV cycles toward a commanded target, with abort
// and a single-cycle completion pulse.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int N        = DEFAULT_N,
    parameter int STEP_DIV = DEFAULT_STEP_DIV
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CMD_VALID,
    input  logic [N-1:0] CMD_TARGET,
    output logic         CMD_READY,
    input  logic         ABORT,
    output logic [N-1:0] Y,
    output logic         DIR_OUT,
    output logic         BUSY,
    output logic         DONE
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [N-1:0]  Y_MAX      = '1;

    // State literals are package-qualified because the DONE port shadows the enum name.
    count_seq_pkg::state_e state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [N-1:0]  target_q, target_d;
    logic          dir_q, dir_d;
    logic          stepEn;
    logic [N-1:0]  count;
    logic [N-1:0]  yNext;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        target_d = target_q;
        dir_d    = dir_q;
        stepEn   = 1'b0;

        // Position after a step this cycle, so arrival can be detected on the stepping edge.
        if (dir_q) begin
            yNext = (count == Y_MAX) ? count : count + 1'b1;
        end else begin
            yNext = (count == '0) ? count : count - 1'b1;
        end

        case (state_q)
            count_seq_pkg::IDLE: begin
                if (CMD_VALID) begin
                    if (CMD_TARGET != count) begin
                        target_d = CMD_TARGET;
                        dir_d    = (CMD_TARGET > count);
                        presc_d  = '0;
                        state_d  = count_seq_pkg::RUN;
                    end else begin
                        state_d  = count_seq_pkg::DONE;
                    end
                end
            end
            count_seq_pkg::RUN: begin
                if (ABORT) begin
                    state_d = count_seq_pkg::IDLE;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    stepEn  = 1'b1;
                    if (yNext == target_q) begin
                        state_d = count_seq_pkg::DONE;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            count_seq_pkg::DONE: begin
                state_d = count_seq_pkg::IDLE;
            end
            default: begin
                state_d = count_seq_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= count_seq_pkg::IDLE;
            presc_q  <= '0;
            target_q <= '0;
            dir_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            target_q <= target_d;
            dir_q    <= dir_d;
        end
    end

    updn_step_counter #(
        .N(N)
    ) u_counter (
        .CLK   (CLK),
        .RESET (RESET),
        .EN    (stepEn),
        .DIR   (dir_q),
        .Q     (count)
    );

    assign Y         = count;
    assign DIR_OUT   = dir_q;
    assign CMD_READY = (state_q == count_seq_pkg::IDLE);
    assign BUSY      = (state_q == count_seq_pkg::RUN);
    assign DONE      = (state_q == count_seq_pkg::DONE);

endmodule
